// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA arbiter for the shared SRAM processor port
module mem_arbiter #(
  parameter int ADDR_WIDTH = 18,
  parameter int WORD_WIDTH = 36,
  parameter int NXM_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0] cpu_write_data,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic                  cpu_user,
  output logic [WORD_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_ack,
  output logic                  cpu_nxm,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [WORD_WIDTH-1:0] dma_write_data,
  input  logic                  dma_read,
  input  logic                  dma_write,
  input  logic                  dma_user,
  output logic [WORD_WIDTH-1:0] dma_read_data,
  output logic                  dma_ack,
  output logic                  dma_nxm,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_user,
  input  logic [WORD_WIDTH-1:0] mem_read_data,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DMA, DONE} state_t;

  localparam int CNT_WIDTH = (NXM_CYCLES > 2) ? $clog2(NXM_CYCLES) : 1;

  state_t               state, state_next;
  logic                 last_grant;  // 1 = DMA held the port last
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cpu_req, dma_req, grant, grant_dma;
  logic                 owner_req, owner_ack, timeout, complete;

  assign cpu_req   = cpu_read | cpu_write;
  assign dma_req   = dma_read | dma_write;
  assign grant     = (cpu_req | dma_req) & ~mem_ack;
  assign grant_dma = dma_req & (~cpu_req | ~last_grant);
  assign owner_req = last_grant ? dma_req : cpu_req;
  assign owner_ack = last_grant ? dma_ack : cpu_ack;
  // The edge that would take the counter to NXM_CYCLES-1 is the timeout edge.
  assign timeout   = (cnt == CNT_WIDTH'(NXM_CYCLES - 2));
  assign complete  = mem_ack | timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:               if (grant) state_next = grant_dma ? BUSY_DMA : BUSY_CPU;
      BUSY_CPU, BUSY_DMA: if (complete) state_next = DONE;
      // Once the ack has been withdrawn the requester has released; only a stale mem_ack holds us.
      DONE:               if (!mem_ack && (!owner_req || !owner_ack)) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant     <= 1'b1;
      cnt            <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_user       <= 1'b0;
      cpu_read_data  <= '0;
      cpu_ack        <= 1'b0;
      cpu_nxm        <= 1'b0;
      dma_read_data  <= '0;
      dma_ack        <= 1'b0;
      dma_nxm        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          mem_addr       <= grant_dma ? dma_addr : cpu_addr;
          mem_write_data <= grant_dma ? dma_write_data : cpu_write_data;
          mem_user       <= grant_dma ? dma_user : cpu_user;
          mem_write      <= grant_dma ? dma_write : cpu_write;
          mem_read       <= grant_dma ? (dma_read & ~dma_write) : (cpu_read & ~cpu_write);
          cnt            <= '0;
          last_grant     <= grant_dma;
        end
        BUSY_CPU, BUSY_DMA: begin
          cnt <= cnt + 1'b1;
          if (complete) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (state == BUSY_DMA) begin
              dma_ack <= 1'b1;
              dma_nxm <= ~mem_ack;
              if (mem_read) dma_read_data <= mem_ack ? mem_read_data : '0;
            end else begin
              cpu_ack <= 1'b1;
              cpu_nxm <= ~mem_ack;
              if (mem_read) cpu_read_data <= mem_ack ? mem_read_data : '0;
            end
          end
        end
        DONE: if (!owner_req) begin
          cpu_ack <= 1'b0;
          cpu_nxm <= 1'b0;
          dma_ack <= 1'b0;
          dma_nxm <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single processor-side port of the SRAM memory interface between the CPU and a DMA requester (console/front-panel and I/O device transfers). It grants one requester at a time, sequences the full level-handshake to memory, returns read data and acknowledges to the winner, and times out accesses that never complete, reporting nonexistent memory (NXM). It sits between the CPU/DMA masters and the SRAM memory controller.

## Interface
- ADDR_WIDTH, 18, word address width
- WORD_WIDTH, 36, data word width
- NXM_CYCLES, 64, clk cycles granted memory has to ack before NXM abort (≥2)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr / dma_addr  in  ADDR_WIDTH  requester word address
- cpu_write_data / dma_write_data  in  WORD_WIDTH  write data
- cpu_read / dma_read  in  1  read request, level, held until ack
- cpu_write / dma_write  in  1  write request, level, held until ack
- cpu_user / dma_user  in  1  user (1) / exec (0) space select
- cpu_read_data / dma_read_data  out  WORD_WIDTH  registered read data
- cpu_ack / dma_ack  out  1  completion acknowledge
- cpu_nxm / dma_nxm  out  1  asserted with ack when access timed out
- mem_addr  out  ADDR_WIDTH  to memory controller
- mem_write_data  out  WORD_WIDTH  to memory controller
- mem_read, mem_write  out  1  memory request, at most one high
- mem_user  out  1  user/exec select to memory
- mem_read_data  in  WORD_WIDTH  from memory controller
- mem_ack  in  1  memory completion; memory drops it after request drops

## Operation
- States: IDLE, BUSY_CPU, BUSY_DMA, DONE.
- Reset: state IDLE; every output 0 (acks, nxm, mem_read, mem_write, mem_user, mem_addr, mem_write_data, read_data); last_grant = DMA (so CPU wins first contention); timeout counter 0.
- A port requests when its read or write is high; read and write both high on one port is treated as write.
- IDLE: one requester → grant it. Both → grant the port not equal to last_grant. On grant: latch addr, write_data, user, op into mem_* registers, assert mem_read or mem_write, clear counter, update last_grant, go BUSY_x.
- IDLE also waits for mem_ack low before granting (guards against a stale ack).
- BUSY_x: mem_* held stable; counter increments each cycle.
  - mem_ack high: x_read_data ← mem_read_data on reads (unchanged on writes); x_ack ← 1; x_nxm ← 0; drop mem_read/mem_write; go DONE.
  - counter reaches NXM_CYCLES−1 with no ack: x_ack ← 1, x_nxm ← 1, x_read_data ← 0 on reads; drop mem request; go DONE.
  - Other port's requests ignored (it waits).
- DONE: x_ack (and x_nxm) held until granted requester drops both read and write; then clear them. Leave to IDLE only when requester is low and mem_ack is low.
- Requester dropping its request before ack: access still runs to ack/timeout; ack then pulses one cycle in DONE and clears.
- Reset asserted mid-access: immediate return to reset values; memory sees request drop.

## Timing
- Request sampled high at edge N in IDLE → mem_read/mem_write high after edge N.
- mem_ack sampled high at edge M → x_ack high and mem request low after edge M; read data valid same cycle as x_ack.
- NXM: request asserted after edge N, no ack → x_ack+x_nxm high after edge N+NXM_CYCLES−1.
- Requester drops at edge K (mem_ack already low) → x_ack low and state IDLE after edge K; earliest next grant edge K+1 (one idle cycle between transactions).
- Never more than one of mem_read, mem_write high; never both acks high.

## Test plan
- CPU read alone, mem_ack after 5 cycles with mem_read_data=36'o123456701234 → cpu_read_data=that value, cpu_ack 1, cpu_nxm 0, dma_ack stays 0.
- CPU write and DMA write raised same edge after reset → CPU granted first (mem_addr=cpu_addr), DMA granted next with one idle cycle between; repeat contention → DMA wins (alternation).
- DMA read, mem_ack never asserted, NXM_CYCLES=64 → dma_ack and dma_nxm high 63 cycles after grant, dma_read_data=0, mem_read low.
- CPU read and write both high → mem_write high, mem_read low; mem_user follows cpu_user=1.
- CPU holds request while mem_ack stays high 3 cycles after request drop → no new grant until mem_ack low; pending DMA then granted.
- Reset pulsed during BUSY_DMA → all outputs 0 asynchronously, state IDLE, next contention granted to CPU.
